mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-master arbiter sharing one single-port, zero-latency 32x2048 RAM between the CPU instruction-fetch port and the data load/store port. It sequences every access through an arbitrate/access/respond state machine and registers read data. It also enforces data-over-instruction priority with a bounded starvation guard. It sits between the CPU core and the test RAM and removes the need for separate instruction and data memories.

## Interface
- MAX_DATA_STREAK, 4: max consecutive data grants while an instruction request waits (1..15)
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- instr_address  in  32  instruction byte address
- instr_read  in  1  instruction read request
- instr_waitrequest  out  1  low for exactly the completion cycle of an instruction access
- instr_readdata  out  32  fetched word, valid while instr_waitrequest low
- data_address  in  32  data byte address
- data_read  in  1  data read request
- data_write  in  1  data write request
- data_writedata  in  32  store word
- data_waitrequest  out  1  low for exactly the completion cycle of a data access
- data_readdata  out  32  load word, valid while data_waitrequest low
- ram_address  out  32  RAM word index
- ram_read  out  1  RAM read strobe
- ram_write  out  1  RAM write strobe
- ram_writedata  out  32  RAM write word
- ram_readdata  in  32  RAM combinational read data

## Operation
- States: IDLE, ACC_I, ACC_D, RESP_I, RESP_D.
- A data request is pending when data_read or data_write is high. An instruction request is pending when instr_read is high.
- IDLE arbitration:
  - Only data pending -> ACC_D.
  - Only instruction pending -> ACC_I.
  - Both pending -> ACC_D if streak < MAX_DATA_STREAK, else ACC_I.
  - Neither pending -> stay in IDLE.
- Streak counter, 4 bits:
  - +1 on each IDLE->ACC_D taken while an instruction request is pending.
  - Cleared on IDLE->ACC_I.
  - Cleared on any IDLE->ACC_D taken with no instruction request pending.
- ACC_x, one cycle:
  - ram_address = selected address >> 2; the low 2 bits are ignored, no misalignment error.
  - ACC_I: ram_read = 1.
  - ACC_D: ram_read = data_read & ~data_write; ram_write = data_write; ram_writedata = data_writedata.
  - If data_read and data_write are both high, the access is a write and data_readdata returns 0.
  - ram_readdata is captured into a response register at the end of the cycle (0 for writes).
  - Next state is RESP_x.
- RESP_x, one cycle: waitrequest for master x is low and its readdata = response register. Next state is IDLE.
- Outside its RESP cycle, each waitrequest is high and each readdata holds the last response value.
- Masters hold address, control and writedata stable from request until the RESP cycle. A request still high in the cycle after RESP is a new transaction.
- RAM strobes are 0 in IDLE and RESP states.

## Timing
- Reset (rst_n low at a rising edge):
  - State = IDLE, streak = 0, response registers = 0.
  - instr_waitrequest = 1, data_waitrequest = 1, ram_read = 0, ram_write = 0.
- ram_write and ram_read are gated by rst_n. Reset asserted during ACC_D suppresses the write, and the access is aborted with no RESP cycle.
- Latency: request first seen in IDLE at cycle 0 -> ACC at cycle 1 -> waitrequest low at cycle 2. The RAM write commits at the edge ending cycle 1.
- Throughput: one access per 3 cycles. There is no back-to-back grant without passing through IDLE.
- Arbitration is evaluated only in IDLE. A request arriving during ACC or RESP waits for the next IDLE.
- Simultaneous requests never produce two RAM strobes in one cycle. At most one waitrequest is low in any cycle.

## Test plan
- Reset: hold rst_n = 0 for 2 cycles with both masters requesting -> both waitrequest = 1, ram_read = ram_write = 0, readdata = 0. First grant goes to data 1 cycle after rst_n rises.
- Single read: preload word index 5 = 0xDEADBEEF; instr_read with instr_address = 0x14 at cycle 0 -> ram_read = 1 and ram_address = 5 at cycle 1; instr_waitrequest = 0 and instr_readdata = 0xDEADBEEF at cycle 2 only.
- Write then read: data_write with address 0x20 and writedata 0x12345678, then data_read with address 0x23 -> RAM word 8 updated after the write ACC; read returns 0x12345678 (low bits ignored).
- Starvation guard, MAX_DATA_STREAK = 4: data and instruction requesting continuously -> grant order D,D,D,D,I,D,D,D,D,I. Each grant spans 3 cycles.
- Reset mid-write: pulse rst_n low during ACC_D of a write of 0xFFFFFFFF to word 3 (was 0) -> word 3 stays 0, no RESP_D, data_waitrequest stays 1.
- Both strobes: data_read = data_write = 1, writedata 0xA5A5A5A5 to word 9 -> ram_write = 1, ram_read = 0; data_readdata = 0 in RESP_D; word 9 = 0xA5A5A5A5.

Source files
------------

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================
// mem_arbiter_if: CPU instruction/data ports and RAM port bundle
// Rev 1.0
// ============================================================
interface mem_arbiter_if;
  logic [31:0] instr_address;
  logic        instr_read;
  logic        instr_waitrequest;
  logic [31:0] instr_readdata;

  logic [31:0] data_address;
  logic        data_read;
  logic        data_write;
  logic [31:0] data_writedata;
  logic        data_waitrequest;
  logic [31:0] data_readdata;

  logic [31:0] ram_address;
  logic        ram_read;
  logic        ram_write;
  logic [31:0] ram_writedata;
  logic [31:0] ram_readdata;

  // Arbiter side: takes CPU requests and RAM read data, drives responses and RAM strobes.
  modport slave (
    input  instr_address, instr_read,
    input  data_address, data_read, data_write, data_writedata,
    input  ram_readdata,
    output instr_waitrequest, instr_readdata,
    output data_waitrequest, data_readdata,
    output ram_address, ram_read, ram_write, ram_writedata
  );

  modport master (
    output instr_address, instr_read,
    output data_address, data_read, data_write, data_writedata,
    output ram_readdata,
    input  instr_waitrequest, instr_readdata,
    input  data_waitrequest, data_readdata,
    input  ram_address, ram_read, ram_write, ram_writedata
  );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================
// mem_arbiter: shares one zero-latency RAM between I-fetch and data ports
// Rev 1.0
// ============================================================
module mem_arbiter #(
  parameter int MAX_DATA_STREAK = 4
) (
  input  wire           clk,
  input  wire           rst_n,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACC_I  = 3'd1,
    ACC_D  = 3'd2,
    RESP_I = 3'd3,
    RESP_D = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  streak_q, streak_d;
  logic [31:0] instr_resp_q, instr_resp_d;
  logic [31:0] data_resp_q, data_resp_d;

  logic data_pend;
  logic instr_pend;

  assign data_pend  = bus.data_read | bus.data_write;
  assign instr_pend = bus.instr_read;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      streak_q     <= 4'd0;
      instr_resp_q <= 32'd0;
      data_resp_q  <= 32'd0;
    end else begin
      state_q      <= state_d;
      streak_q     <= streak_d;
      instr_resp_q <= instr_resp_d;
      data_resp_q  <= data_resp_d;
    end
  end

  always_comb begin
    state_d               = state_q;
    streak_d              = streak_q;
    instr_resp_d          = instr_resp_q;
    data_resp_d           = data_resp_q;
    bus.ram_address       = 32'd0;
    bus.ram_read          = 1'b0;
    bus.ram_write         = 1'b0;
    bus.ram_writedata     = 32'd0;
    bus.instr_waitrequest = 1'b1;
    bus.data_waitrequest  = 1'b1;

    case (state_q)
      IDLE: begin
        // Data wins unless it has already taken MAX_DATA_STREAK grants past a waiting fetch.
        if (data_pend && (!instr_pend || (streak_q < 4'(MAX_DATA_STREAK)))) begin
          state_d  = ACC_D;
          streak_d = instr_pend ? (streak_q + 4'd1) : 4'd0;
        end else if (instr_pend) begin
          state_d  = ACC_I;
          streak_d = 4'd0;
        end
      end
      ACC_I: begin
        bus.ram_address = bus.instr_address >> 2;
        bus.ram_read    = rst_n;
        instr_resp_d    = bus.ram_readdata;
        state_d         = RESP_I;
      end
      ACC_D: begin
        bus.ram_address   = bus.data_address >> 2;
        bus.ram_read      = rst_n & bus.data_read & ~bus.data_write;
        bus.ram_write     = rst_n & bus.data_write;
        bus.ram_writedata = bus.data_writedata;
        data_resp_d       = bus.data_write ? 32'd0 : bus.ram_readdata;
        state_d           = RESP_D;
      end
      RESP_I: begin
        bus.instr_waitrequest = 1'b0;
        state_d               = IDLE;
      end
      RESP_D: begin
        bus.data_waitrequest = 1'b0;
        state_d              = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.instr_readdata = instr_resp_q;
  assign bus.data_readdata  = data_resp_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================
// tb_mem_arbiter: randomized scoreboard bench for mem_arbiter
// Rev 1.0
// ============================================================
module tb_mem_arbiter;
  localparam int MAXS     = 4;
  localparam int MAX_WAIT = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if bus ();

  mem_arbiter #(.MAX_DATA_STREAK(MAXS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // RAM storage (environment) and reference memory contents (model)
  logic [31:0] ram_mem [0:2047];
  logic [31:0] mdl     [0:2047];

  assign bus.ram_readdata = ram_mem[bus.ram_address[10:0]];
  always @(posedge clk) if (bus.ram_write === 1'b1) ram_mem[bus.ram_address[10:0]] <= bus.ram_writedata;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [31:0] exp_i[$];
  logic [31:0] exp_d[$];
  bit          log_en = 1'b0;
  bit          glog[$];
  int          gcyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops expected responses whenever a master sees its completion cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (!bus.instr_waitrequest && !bus.data_waitrequest) begin
        failures++;
        $display("FAIL both_wait_low: instr=%b data=%b required not both 0", bus.instr_waitrequest, bus.data_waitrequest);
      end
      checks++;
      if (bus.ram_read && bus.ram_write) begin
        failures++;
        $display("FAIL both_strobes: read=%b write=%b", bus.ram_read, bus.ram_write);
      end
      if (bus.instr_waitrequest === 1'b0) begin
        if (log_en) begin glog.push_back(1'b1); gcyc.push_back(cyc); end
        if (exp_i.size() == 0) begin
          checks++; failures++;
          $display("FAIL instr_unexpected: readdata %h with no expected entry", bus.instr_readdata);
        end else chk("instr_readdata", bus.instr_readdata, exp_i.pop_front());
      end
      if (bus.data_waitrequest === 1'b0) begin
        if (log_en) begin glog.push_back(1'b0); gcyc.push_back(cyc); end
        if (exp_d.size() == 0) begin
          checks++; failures++;
          $display("FAIL data_unexpected: readdata %h with no expected entry", bus.data_readdata);
        end else chk("data_readdata", bus.data_readdata, exp_d.pop_front());
      end
    end
  end

  task automatic data_txn(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] wd);
    logic [10:0] idx;
    int n;
    idx = addr[12:2];
    if (wr) begin
      exp_d.push_back(32'd0);
      mdl[idx] = wd;
    end else exp_d.push_back(mdl[idx]);
    bus.data_address   = addr;
    bus.data_read      = rd;
    bus.data_write     = wr;
    bus.data_writedata = wd;
    n = 0;
    do begin tick(); n++; end while (bus.data_waitrequest === 1'b1 && n < MAX_WAIT);
    chk("data_timeout", {31'd0, bus.data_waitrequest}, 32'd0);
    tick();
    bus.data_read  = 1'b0;
    bus.data_write = 1'b0;
  endtask

  task automatic instr_txn(input logic [31:0] addr);
    logic [10:0] idx;
    int n;
    idx = addr[12:2];
    exp_i.push_back(mdl[idx]);
    bus.instr_address = addr;
    bus.instr_read    = 1'b1;
    n = 0;
    do begin tick(); n++; end while (bus.instr_waitrequest === 1'b1 && n < MAX_WAIT);
    chk("instr_timeout", {31'd0, bus.instr_waitrequest}, 32'd0);
    tick();
    bus.instr_read = 1'b0;
  endtask

  // Data traffic lives in words 1024..2047, fetches in 0..1023, so concurrent
  // masters never race on the same word and expectations are order-independent.
  task automatic rand_data_txn();
    int op;
    logic [31:0] a;
    op = $urandom_range(0, 2);
    a  = 32'h1000 | ($urandom_range(0, 32'hFFF));
    data_txn(op != 1, op != 0, a, $urandom);
  endtask

  task automatic rand_instr_txn();
    instr_txn($urandom_range(0, 32'hFFF));
  endtask

  initial begin
    int n;
    bit exp_g;
    int cnt;
    for (int i = 0; i < 2048; i++) begin
      mdl[i] = $urandom;
    end
    mdl[3] = 32'd0;
    mdl[5] = 32'hDEADBEEF;
    for (int i = 0; i < 2048; i++) ram_mem[i] = mdl[i];

    // Reset with both masters requesting
    bus.instr_address = 32'h40; bus.instr_read = 1'b1;
    bus.data_address = 32'h1004; bus.data_read = 1'b1;
    bus.data_write = 1'b0; bus.data_writedata = 32'd0;
    exp_d.push_back(mdl[1025]);
    exp_i.push_back(mdl[16]);
    repeat (2) begin
      tick();
      chk("rst_instr_wait", {31'd0, bus.instr_waitrequest}, 32'd1);
      chk("rst_data_wait", {31'd0, bus.data_waitrequest}, 32'd1);
      chk("rst_strobes", {30'd0, bus.ram_read, bus.ram_write}, 32'd0);
      chk("rst_instr_rdata", bus.instr_readdata, 32'd0);
      chk("rst_data_rdata", bus.data_readdata, 32'd0);
    end
    rst_n = 1'b1;
    tick();
    chk("first_grant_data_read", {31'd0, bus.ram_read}, 32'd1);
    chk("first_grant_addr", bus.ram_address, 32'd1025);
    tick();
    chk("first_grant_done", {31'd0, bus.data_waitrequest}, 32'd0);
    tick();
    bus.data_read = 1'b0;
    n = 0;
    do begin tick(); n++; end while (bus.instr_waitrequest === 1'b1 && n < MAX_WAIT);
    chk("rst_instr_follow", {31'd0, bus.instr_waitrequest}, 32'd0);
    tick();
    bus.instr_read = 1'b0;

    // Single instruction read with exact latency
    exp_i.push_back(32'hDEADBEEF);
    bus.instr_address = 32'h14; bus.instr_read = 1'b1;
    tick();
    chk("rd_acc_strobe", {31'd0, bus.ram_read}, 32'd1);
    chk("rd_acc_addr", bus.ram_address, 32'd5);
    chk("rd_acc_wait", {31'd0, bus.instr_waitrequest}, 32'd1);
    tick();
    chk("rd_resp_wait", {31'd0, bus.instr_waitrequest}, 32'd0);
    chk("rd_resp_data", bus.instr_readdata, 32'hDEADBEEF);
    tick();
    bus.instr_read = 1'b0;
    chk("rd_after_wait", {31'd0, bus.instr_waitrequest}, 32'd1);
    chk("rd_hold_data", bus.instr_readdata, 32'hDEADBEEF);

    // Write then read back with unaligned address
    data_txn(1'b0, 1'b1, 32'h20, 32'h12345678);
    chk("wr_ram_word8", ram_mem[8], 32'h12345678);
    data_txn(1'b1, 1'b0, 32'h23, 32'd0);
    chk("rd_back_hold", bus.data_readdata, 32'h12345678);

    // Reset pulse during write access
    bus.data_address = 32'h0C; bus.data_writedata = 32'hFFFFFFFF; bus.data_write = 1'b1;
    tick();
    chk("abort_wr_strobe", {31'd0, bus.ram_write}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_wr_gated", {31'd0, bus.ram_write}, 32'd0);
    tick();
    rst_n = 1'b1; bus.data_write = 1'b0;
    chk("abort_rdata_clr", bus.data_readdata, 32'd0);
    repeat (3) begin
      chk("abort_no_resp", {31'd0, bus.data_waitrequest}, 32'd1);
      tick();
    end
    chk("abort_word3", ram_mem[3], 32'd0);

    // Read and write both high: treated as write
    exp_d.push_back(32'd0);
    mdl[9] = 32'hA5A5A5A5;
    bus.data_address = 32'h24; bus.data_writedata = 32'hA5A5A5A5;
    bus.data_read = 1'b1; bus.data_write = 1'b1;
    tick();
    chk("both_wr", {31'd0, bus.ram_write}, 32'd1);
    chk("both_rd", {31'd0, bus.ram_read}, 32'd0);
    chk("both_addr", bus.ram_address, 32'd9);
    tick();
    chk("both_wait", {31'd0, bus.data_waitrequest}, 32'd0);
    chk("both_rdata", bus.data_readdata, 32'd0);
    tick();
    bus.data_read = 1'b0; bus.data_write = 1'b0;
    chk("both_word9", ram_mem[9], 32'hA5A5A5A5);

    // Starvation guard: both masters request back to back
    glog.delete(); gcyc.delete();
    log_en = 1'b1;
    fork
      begin repeat (8) rand_data_txn(); end
      begin repeat (2) rand_instr_txn(); end
    join
    log_en = 1'b0;
    chk("starve_count", glog.size(), 32'd10);
    cnt = 0;
    for (int k = 0; k < 10 && k < glog.size(); k++) begin
      if (cnt < MAXS) begin exp_g = 1'b0; cnt++; end
      else begin exp_g = 1'b1; cnt = 0; end
      chk($sformatf("starve_grant%0d", k), {31'd0, glog[k]}, {31'd0, exp_g});
      if (k > 0) chk($sformatf("starve_gap%0d", k), gcyc[k] - gcyc[k-1], 32'd3);
    end

    // Random concurrent traffic
    fork
      begin
        repeat (40) begin
          rand_data_txn();
          repeat ($urandom_range(0, 3)) tick();
        end
      end
      begin
        repeat (30) begin
          rand_instr_txn();
          repeat ($urandom_range(0, 3)) tick();
        end
      end
    join
    repeat (4) tick();
    chk("exp_i_drained", exp_i.size(), 32'd0);
    chk("exp_d_drained", exp_d.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
